// File: rtl/game_ctrl_if.sv
// game_ctrl_if: button/collision inputs and status outputs of the game sequencer
interface game_ctrl_if #(parameter int SCORE_W = 14);
  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               hit;
  logic [2:0]         state;
  logic               running;
  logic [1:0]         countdown;
  logic               flash;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic [2:0]         level;
  modport master (
    output frame_tick, start_btn, pause_btn, hit,
    input  state, running, countdown, flash, score, hiscore, level
  );
  modport slave (
    input  frame_tick, start_btn, pause_btn, hit,
    output state, running, countdown, flash, score, hiscore, level
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: clocked game sequencer with countdown, frame-based score, speed level and high score
module game_ctrl #(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int DEATH_FRAMES     = 64,
  parameter int SCORE_DIV        = 4,
  parameter int SCORE_W          = 14,
  parameter int LEVEL_SHIFT      = 9
) (
  input logic       clk,
  input logic       reset,
  game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COUNT, RUN, PAUSE, DYING, OVER} state_t;
  localparam int FMAX = (3 * FRAMES_PER_DIGIT > DEATH_FRAMES) ? 3 * FRAMES_PER_DIGIT : DEATH_FRAMES;
  localparam int FW   = ($clog2(FMAX) > 4) ? $clog2(FMAX) : 4;
  localparam int DW   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  state_t             st;
  logic [FW-1:0]      fcnt;
  logic [FW-1:0]      fnext;
  logic [DW-1:0]      div;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic [2:0]         level;
  logic [1:0]         countdown;
  logic               running;
  logic               flash;
  logic               start_q;
  logic               pause_q;
  logic               start_rise;
  logic               pause_rise;
  logic               tick;
  logic               div_wrap;
  assign fnext    = fcnt + 1'b1;
  assign tick     = bus.frame_tick;
  assign div_wrap = div == DW'(SCORE_DIV - 1);
  function automatic logic [1:0] digit(input logic [FW-1:0] f);
    digit = (f < FW'(FRAMES_PER_DIGIT)) ? 2'd3 : (f < FW'(2 * FRAMES_PER_DIGIT)) ? 2'd2 : 2'd1;
  endfunction
  function automatic logic [2:0] lvl(input logic [SCORE_W-1:0] s);
    lvl = ((s >> LEVEL_SHIFT) > SCORE_W'(7)) ? 3'd7 : 3'(s >> LEVEL_SHIFT);
  endfunction
  // Registered rising-edge detectors; previous levels reset high so a held button gives no edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      start_rise <= 1'b0;
      pause_rise <= 1'b0;
    end else begin
      start_q    <= bus.start_btn;
      pause_q    <= bus.pause_btn;
      start_rise <= bus.start_btn & ~start_q;
      pause_rise <= bus.pause_btn & ~pause_q;
    end
  // Game state machine with counters and registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st        <= IDLE;
      fcnt      <= '0;
      div       <= '0;
      score     <= '0;
      hiscore   <= '0;
      level     <= '0;
      running   <= 1'b0;
      countdown <= 2'd0;
      flash     <= 1'b0;
    end else begin
      level <= lvl(score);
      case (st)
        IDLE, OVER:
          if (start_rise) begin
            st        <= COUNT;
            fcnt      <= '0;
            div       <= '0;
            score     <= '0;
            level     <= '0;
            countdown <= 2'd3;
          end
        COUNT:
          if (tick) begin
            if (fcnt == FW'(3 * FRAMES_PER_DIGIT - 1)) begin
              st        <= RUN;
              fcnt      <= '0;
              running   <= 1'b1;
              countdown <= 2'd0;
            end else begin
              fcnt      <= fnext;
              countdown <= digit(fnext);
            end
          end
        RUN:
          if (tick && bus.hit) begin
            st      <= DYING;
            fcnt    <= '0;
            running <= 1'b0;
            flash   <= 1'b0;
          end else begin
            if (tick) begin
              div <= div_wrap ? '0 : div + 1'b1;
              if (div_wrap && score != '1) score <= score + 1'b1;
            end
            if (pause_rise) begin
              st      <= PAUSE;
              running <= 1'b0;
            end
          end
        PAUSE:
          if (pause_rise) begin
            st      <= RUN;
            running <= 1'b1;
          end
        DYING:
          if (tick) begin
            if (fcnt == FW'(DEATH_FRAMES - 1)) begin
              st    <= OVER;
              fcnt  <= '0;
              flash <= 1'b0;
              if (score > hiscore) hiscore <= score;
            end else begin
              fcnt  <= fnext;
              flash <= fnext[3];
            end
          end
        default: begin
          st        <= IDLE;
          fcnt      <= '0;
          running   <= 1'b0;
          countdown <= 2'd0;
          flash     <= 1'b0;
        end
      endcase
    end
  assign bus.state     = st;
  assign bus.running   = running;
  assign bus.countdown = countdown;
  assign bus.flash     = flash;
  assign bus.score     = score;
  assign bus.hiscore   = hiscore;
  assign bus.level     = level;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl
module tb_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  game_ctrl_if #(.SCORE_W(14)) f();
  game_ctrl_if #(.SCORE_W(6))  g();
  game_ctrl #(.FRAMES_PER_DIGIT(2), .DEATH_FRAMES(64), .SCORE_DIV(4), .SCORE_W(14), .LEVEL_SHIFT(9))
    dut (.clk(clk), .reset(reset), .bus(f));
  game_ctrl #(.FRAMES_PER_DIGIT(1), .DEATH_FRAMES(8), .SCORE_DIV(1), .SCORE_W(6), .LEVEL_SHIFT(3))
    dut_small (.clk(clk), .reset(reset), .bus(g));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tick(input int n);
    f.frame_tick = 1'b1;
    g.frame_tick = 1'b1;
    step(n);
    f.frame_tick = 1'b0;
    g.frame_tick = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    int cd[5] = '{3, 2, 2, 1, 1};
    f.frame_tick = 0; f.start_btn = 1; f.pause_btn = 0; f.hit = 0;
    g.frame_tick = 0; g.start_btn = 0; g.pause_btn = 0; g.hit = 0;
    step(3);
    chk("rst_state", 32'(f.state), 0);
    chk("rst_running", 32'(f.running), 0);
    chk("rst_countdown", 32'(f.countdown), 0);
    chk("rst_flash", 32'(f.flash), 0);
    chk("rst_score", 32'(f.score), 0);
    chk("rst_hiscore", 32'(f.hiscore), 0);
    chk("rst_level", 32'(f.level), 0);
    reset = 1'b1;
    step(3);
    chk("held_start_idle", 32'(f.state), 0);
    f.start_btn = 0;
    step(1);
    f.start_btn = 1;
    step(1);
    chk("start_1clk_idle", 32'(f.state), 0);
    step(1);
    chk("start_2clk_count", 32'(f.state), 1);
    chk("cd_entry", 32'(f.countdown), 3);
    f.start_btn = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("cd_tick%0d", i + 1), 32'(f.countdown), 32'(cd[i]));
      chk($sformatf("cd_state%0d", i + 1), 32'(f.state), 1);
    end
    tick(1);
    chk("run_state", 32'(f.state), 2);
    chk("run_running", 32'(f.running), 1);
    chk("run_countdown", 32'(f.countdown), 0);
    tick(40);
    chk("score_40ticks", 32'(f.score), 10);
    f.hit = 1;
    step(3);
    f.hit = 0;
    chk("hit_no_tick", 32'(f.state), 2);
    tick(1);
    chk("hit_dropped", 32'(f.state), 2);
    chk("score_div1", 32'(f.score), 10);
    f.pause_btn = 1;
    step(2);
    f.pause_btn = 0;
    chk("pause_state", 32'(f.state), 3);
    chk("pause_running", 32'(f.running), 0);
    tick(20);
    chk("pause_frozen", 32'(f.score), 10);
    chk("pause_hold", 32'(f.state), 3);
    f.pause_btn = 1;
    step(2);
    f.pause_btn = 0;
    chk("resume_state", 32'(f.state), 2);
    chk("resume_running", 32'(f.running), 1);
    tick(3);
    chk("resume_count", 32'(f.score), 11);
    tick(2003);
    chk("score_511", 32'(f.score), 511);
    chk("level_at_511", 32'(f.level), 0);
    tick(1);
    chk("score_512", 32'(f.score), 512);
    chk("level_lag", 32'(f.level), 0);
    step(1);
    chk("level_1", 32'(f.level), 1);
    f.pause_btn = 1;
    step(1);
    f.hit = 1;
    f.frame_tick = 1;
    step(1);
    f.hit = 0;
    f.frame_tick = 0;
    f.pause_btn = 0;
    chk("pause_vs_hit", 32'(f.state), 4);
    chk("dying_running", 32'(f.running), 0);
    chk("dying_flash0", 32'(f.flash), 0);
    tick(7);
    chk("flash_t7", 32'(f.flash), 0);
    tick(1);
    chk("flash_t8", 32'(f.flash), 1);
    tick(8);
    chk("flash_t16", 32'(f.flash), 0);
    tick(47);
    chk("dying_t63", 32'(f.state), 4);
    tick(1);
    chk("over_state", 32'(f.state), 5);
    chk("over_hiscore", 32'(f.hiscore), 512);
    chk("over_score", 32'(f.score), 512);
    chk("over_level", 32'(f.level), 1);
    chk("over_flash", 32'(f.flash), 0);
    f.start_btn = 1;
    step(2);
    f.start_btn = 0;
    chk("g2_count", 32'(f.state), 1);
    chk("g2_score0", 32'(f.score), 0);
    chk("g2_level0", 32'(f.level), 0);
    tick(6);
    chk("g2_run", 32'(f.state), 2);
    tick(8);
    chk("g2_score", 32'(f.score), 2);
    f.hit = 1;
    tick(1);
    f.hit = 0;
    chk("g2_dying", 32'(f.state), 4);
    tick(64);
    chk("g2_over", 32'(f.state), 5);
    chk("g2_hiscore", 32'(f.hiscore), 512);
    chk("g2_score_hold", 32'(f.score), 2);
    reset = 1'b0;
    #1;
    chk("rst_over_state", 32'(f.state), 0);
    chk("rst_over_score", 32'(f.score), 0);
    chk("rst_over_hiscore", 32'(f.hiscore), 0);
    chk("rst_over_running", 32'(f.running), 0);
    step(1);
    reset = 1'b1;
    step(1);
    g.start_btn = 1;
    step(2);
    g.start_btn = 0;
    chk("sm_count", 32'(g.state), 1);
    tick(3);
    chk("sm_run", 32'(g.state), 2);
    tick(62);
    step(1);
    chk("sm_score62", 32'(g.score), 62);
    chk("sm_level_sat", 32'(g.level), 7);
    tick(6);
    chk("sm_score_sat", 32'(g.score), 63);
    chk("sm_still_run", 32'(g.state), 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
